mult_div_ctrl: RTL and testbench

//   Multi-cycle signed MULT/DIV engine and sequencer for the HI/LO registers of the multicycle CPU.
//   The control unit pulses start with an opcode and the A/B register values, then waits in a

---
 rtl/mult_div_ctrl_if.sv | 26 ++
 rtl/mult_div_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_ctrl_if.sv
// Handshake and result bus between the CPU control unit and the MULT/DIV engine.
interface mult_div_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_zero;

    // Control unit side: issues requests, observes results.
    modport master (
        output start, op, A, B,
        input  HI, LO, busy, done, div_zero
    );

    // Engine side: accepts requests, owns HI/LO and status.
    modport slave (
        input  start, op, A, B,
        output HI, LO, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring on magnitudes) engine
// that owns the HI/LO registers. One iteration per clock, WIDTH iterations.
module mult_div_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             op_q, op_d;
    logic             qneg_q, qneg_d;      // quotient must be negated
    logic             rneg_q, rneg_d;      // remainder must be negated
    // MULT: {acc_hi, acc_lo, acc_m} is the Booth accumulator, hi one bit wider
    //       so add/sub of a sign-extended MIN_INT multiplicand cannot overflow.
    // DIV : acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic             acc_m_q, acc_m_d;
    // MULT: sign-extended multiplicand; DIV: zero-extended divisor magnitude.
    logic [WIDTH:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Next-state and datapath logic for the IDLE/RUN/FIN sequencer.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        acc_m_d  = acc_m_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        sum      = '0;
        shifted  = '0;
        ge       = 1'b0;
        a_mag    = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
        b_mag    = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    dz_d     = 1'b0;
                    busy_d   = 1'b1;
                    count_d  = '0;
                    acc_hi_d = '0;
                    acc_m_d  = 1'b0;
                    state_d  = RUN;
                    if (!bus.op) begin
                        acc_lo_d = bus.B;
                        opnd_d   = {bus.A[WIDTH-1], bus.A};
                    end else begin
                        acc_lo_d = a_mag;
                        opnd_d   = {1'b0, b_mag};
                        qneg_d   = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        rneg_d   = bus.A[WIDTH-1];
                        if (bus.B == '0) begin
                            dz_d    = 1'b1;
                            state_d = FIN;
                        end
                    end
                end
            end
            RUN: begin
                count_d = count_q + CW'(1);
                if (!op_q) begin
                    case ({acc_lo_q[0], acc_m_q})
                        2'b01:   sum = acc_hi_q + opnd_q;
                        2'b10:   sum = acc_hi_q - opnd_q;
                        default: sum = acc_hi_q;
                    endcase
                    // Arithmetic shift right of the whole accumulator.
                    {acc_hi_d, acc_lo_d, acc_m_d} = {sum[WIDTH], sum, acc_lo_q};
                end else begin
                    shifted  = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
                    ge       = (shifted >= opnd_q);
                    acc_hi_d = ge ? (shifted - opnd_q) : shifted;
                    acc_lo_d = (acc_lo_q << 1) | WIDTH'(ge);
                end
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!dz_q) begin
                    if (!op_q) begin
                        hi_d = acc_hi_q[WIDTH-1:0];
                        lo_d = acc_lo_q;
                    end else begin
                        lo_d = qneg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
                        hi_d = rneg_q ? (~acc_hi_q[WIDTH-1:0] + 1'b1) : acc_hi_q[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            acc_m_q  <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            acc_m_q  <= acc_m_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: transaction-level reference model compared every
// cycle, directed corner cases with literal results, then random traffic.
module tb_mult_div_ctrl;
    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mult_div_ctrl_if #(.WIDTH(W)) bus();

    mult_div_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model state: what the outputs must show after each edge.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dz   = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_pend = '0;
    logic        m_pend_dz = 1'b0;
    int          m_left = 0;

    // Result of one operation from plain signed arithmetic: {HI, LO}.
    function automatic logic [63:0] ref_result(input logic op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            p   = sa * sb;
            res = p;
        end else if (b == '0) begin
            res = '0;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // Model update: done arrives WIDTH+1 edges after acceptance, or 1 edge for /0.
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (!m_pend_dz) {m_hi, m_lo} = m_pend;
                end
            end else if (bus.start === 1'b1) begin
                m_pend    = ref_result(bus.op, bus.A, bus.B);
                m_pend_dz = bus.op && (bus.B == '0);
                m_dz      = m_pend_dz;
                m_busy    = 1'b1;
                m_left    = m_pend_dz ? 1 : W + 1;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if ({bus.busy, bus.done, bus.div_zero, bus.HI, bus.LO} !==
                {m_busy, m_done, m_dz, m_hi, m_lo}) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got busy=%b done=%b dz=%b HI=%h LO=%h expected busy=%b done=%b dz=%b HI=%h LO=%h",
                         $time, bus.busy, bus.done, bus.div_zero, bus.HI, bus.LO,
                         m_busy, m_done, m_dz, m_hi, m_lo);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge (e0).
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.op = $urandom_range(0, 1);
    endtask

    // Returns at the negedge where done is high; edges counted from e0.
    task automatic wait_done(output int edges);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        if (bus.done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done within 100 edges");
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h0000_0001;
            4: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int edges;
        int dones;
        int done_at;
        bus.start = 1'b0; bus.op = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        chk("reset_HI", bus.HI, 32'h0);
        chk("reset_LO", bus.LO, 32'h0);
        chk("reset_status", {29'd0, bus.busy, bus.done, bus.div_zero}, 32'h0);

        // MULT 7 * -3
        issue(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(edges);
        chk("mult_latency", 32'(edges), 32'd33);
        chk("mult_neg_HI", bus.HI, 32'hFFFF_FFFF);
        chk("mult_neg_LO", bus.LO, 32'hFFFF_FFEB);
        chk("model_mult_LO", m_lo, 32'hFFFF_FFEB);

        // MULT MIN_INT * MIN_INT
        @(negedge clk);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(edges);
        chk("mult_min_HI", bus.HI, 32'h4000_0000);
        chk("mult_min_LO", bus.LO, 32'h0000_0000);

        // DIV -7 / 2, then back-to-back MIN_INT / -1 issued in the done cycle
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges);
        chk("div_neg_LO", bus.LO, 32'hFFFF_FFFD);
        chk("div_neg_HI", bus.HI, 32'hFFFF_FFFF);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges);
        chk("b2b_latency", 32'(edges), 32'd33);
        chk("div_wrap_LO", bus.LO, 32'h8000_0000);
        chk("div_wrap_HI", bus.HI, 32'h0);
        chk("div_wrap_dz", {31'd0, bus.div_zero}, 32'h0);
        chk("model_wrap_LO", m_lo, 32'h8000_0000);

        // DIV 5 / 2 sets HI=1 LO=2, then DIV 5 / 0 must leave them alone
        issue(1'b1, 32'd5, 32'd2);
        wait_done(edges);
        chk("div_prep_HI", bus.HI, 32'd1);
        chk("div_prep_LO", bus.LO, 32'd2);
        issue(1'b1, 32'd5, 32'd0);
        wait_done(edges);
        chk("dz_latency", 32'(edges), 32'd1);
        chk("dz_flag", {31'd0, bus.div_zero}, 32'd1);
        chk("dz_HI_kept", bus.HI, 32'd1);
        chk("dz_LO_kept", bus.LO, 32'd2);
        repeat (4) @(negedge clk);
        chk("dz_sticky", {31'd0, bus.div_zero}, 32'd1);

        // start pulsed at e5 while busy is ignored
        issue(1'b0, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b1; bus.A = 32'd9; bus.B = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        edges = 5; dones = 0; done_at = 0;
        while (edges < 45) begin
            @(negedge clk);
            edges++;
            if (bus.done === 1'b1) begin
                dones++;
                done_at = edges;
            end
        end
        chk("ignore_done_count", 32'(dones), 32'd1);
        chk("ignore_done_edge", 32'(done_at), 32'd33);
        chk("ignore_LO", bus.LO, 32'd15);
        chk("ignore_dz", {31'd0, bus.div_zero}, 32'd0);

        // reset at e10 of a MULT aborts it
        issue(1'b0, 32'h1234, 32'h5678);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_status", {29'd0, bus.busy, bus.done, bus.div_zero}, 32'h0);
        chk("abort_HI", bus.HI, 32'h0);
        chk("abort_LO", bus.LO, 32'h0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);

        // Random traffic, including starts while busy and rare resets
        repeat (8000) begin
            reset     = ($urandom_range(0, 1999) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = $urandom_range(0, 1);
            bus.A     = pick();
            bus.B     = pick();
            @(negedge clk);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
